ahb_dma_channel_arbiter: RTL and testbench
==========================================

Name: ahb_dma_channel_arbiter

Overview:
Shares the single AHB DMA master interface between NUM_CH DMA channels. Each channel requests a burst of N beats; the arbiter picks one channel round-robin and muxes that channel's address, data, size and direction onto the master interface. It sequences the burst's transfer-type controls (NONSEQ/SEQ, burst code, transfer-valid) and counts beats. It reports per-beat acknowledges, completion and error back to the owning channel.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
IDX_W, $clog2(NUM_CH), width of the channel index
BEAT_W, 8, width of the per-channel beat count

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
ch_req  in  NUM_CH  per-channel request; held high until that channel's ch_done or ch_err
ch_beats  in  NUM_CH*BEAT_W  beats in the requested burst; 0 is treated as 1
ch_addr  in  NUM_CH*32  current beat address; channel increments it on ch_ack
ch_wdata  in  NUM_CH*32  current beat write data
ch_size  in  NUM_CH*3  HSIZE encoding (0 byte, 1 half, 2 word)
ch_we  in  NUM_CH  1 = write, 0 = read
ch_grant  out  NUM_CH  one-hot owner of the master interface
ch_ack  out  NUM_CH  one-cycle pulse per accepted beat, to the owner
ch_done  out  NUM_CH  one-cycle pulse after the owner's last beat
ch_err  out  NUM_CH  one-cycle pulse when the owner's burst is aborted
ch_rdata  out  32  read_data passthrough, valid with ch_ack on reads
address  out  32  to master interface
write_data  out  32  to master interface
transfer_size  out  3  to master interface
write_enable  out  1  to master interface
no_trnasfer  out  1  active-low transfer valid, to master interface
burst_seq_transfer  out  1  1 = SEQ beat, 0 = NONSEQ
burst  out  3  HBURST code: 3'b000 SINGLE, 3'b001 INCR
read_data  in  32  from master interface
error  in  1  registered HRESP from master interface
slave_wait  in  1  !HREADY from master interface

Behaviour:
- Reset values: state IDLE; rr_ptr 0; beat_cnt 0; grant 0. All outputs 0, except no_trnasfer = 1.
- States:
  - IDLE: no_trnasfer = 1; mux outputs are 0.
  - XFER: the grant is held.
- IDLE -> XFER when any ch_req is high.
  - Winner is the first set bit at or after rr_ptr, circular.
  - Grant is registered, so ch_grant is visible one cycle after ch_req.
  - beat_cnt loads max(ch_beats[winner], 1).
  - burst_len_is_one is latched from the loaded count.
- XFER outputs:
  - no_trnasfer = 0.
  - address, write_data, transfer_size and write_enable combinationally muxed from the granted channel.
  - burst = 3'b000 if burst_len_is_one, else 3'b001.
  - burst_seq_transfer = 0 on the first beat, 1 on later beats (first_beat flag).
- Beat accepted: in XFER with slave_wait = 0.
  - On acceptance: ch_ack[owner] pulses in the same cycle, beat_cnt decrements, first_beat clears.
  - While slave_wait = 1, all outputs hold and nothing advances.
- Last beat (beat_cnt == 1) accepted:
  - Next cycle: ch_done[owner] pulses, state -> IDLE, grant cleared.
  - rr_ptr = owner + 1, wrapping to 0 after NUM_CH-1.
  - There is always one IDLE cycle between bursts.
- error = 1 in XFER takes priority over beat acceptance in the same cycle.
  - ch_err[owner] pulses next cycle; ch_ack is not asserted for that cycle.
  - state -> IDLE, rr_ptr advances as on completion.
- Owner drops ch_req mid-burst: treated as an abort. No done/err pulse, -> IDLE, rr_ptr advances.
- Simultaneous requests: only the round-robin order matters; ch_req levels in other cycles do not affect the choice.
- ch_rdata = read_data passthrough; the owner samples it on ch_ack when ch_we = 0.
- Asynchronous reset mid-burst: everything returns to reset values immediately. No done/err pulse.

Decomposition:
- Package ahb_dma_arb_pkg holds:
  - typedef enum logic {IDLE, XFER} arb_state_t
  - constants HTRANS_IDLE/NONSEQ/SEQ, HBURST_SINGLE/INCR, HSIZE_BYTE/HALF/WORD
- Sub-module dma_rr_picker (combinational): inputs req vector and rr_ptr; outputs one-hot winner and index.

Test Plan:
- ch_req = 4'b0001, ch_beats[0] = 1, slave_wait = 0 -> one NONSEQ beat with burst = 000, ch_ack[0] once, ch_done[0] the next cycle, no_trnasfer = 1 again.
- ch_req = 4'b0101, beats = 4 each -> ch0 served first with NONSEQ + 3 SEQ and burst = 001, then one IDLE cycle, then ch2; rr_ptr = 3 at the end.
- ch0 burst of 3 with slave_wait = 1 for 2 cycles on beat 2 -> address and seq held, exactly 3 ch_ack pulses, beat_cnt never underflows.
- error = 1 on beat 2 of 4 for ch1 -> ch_err[1] pulses, no ch_done[1], pending ch3 granted after the IDLE cycle.
- ch_beats = 0 -> treated as a single beat, burst = 000.
- rst_n_i low mid-burst -> all outputs at reset values asynchronously; first request after reset is served starting from ch0.

Source files
------------

// File: rtl/ahb_dma_arb_pkg.sv
// Shared types and AHB encodings for the DMA channel arbiter.
package ahb_dma_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   // HTRANS encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // HBURST encodings
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;

   // HSIZE encodings
   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   // Transfer type for the current cycle: first beat of a burst is NONSEQ.
   function automatic logic [1:0] htrans_of(input logic active, input logic first_beat);
      if (!active)
         return HTRANS_IDLE;
      return first_beat ? HTRANS_NONSEQ : HTRANS_SEQ;
   endfunction

endpackage

// File: rtl/dma_rr_picker.sv
// Combinational round-robin picker: first requesting channel at or after
// rr_ptr_i, searching circularly.
module dma_rr_picker #(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IDX_W-1:0]  rr_ptr_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              valid_o
);

   int pos;

   // Walk the channels starting at the pointer and take the first requester.
   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // a value unassigned, which would otherwise infer a latch.
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      pos     = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         // NOTE: blocking assignments here because later iterations must see
         // valid_o already set by earlier ones within the same evaluation.
         pos = (int'(rr_ptr_i) + i) % NUM_CH;
         if (!valid_o && req_i[pos]) begin
            valid_o      = 1'b1;
            grant_o[pos] = 1'b1;
            idx_o        = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/ahb_dma_channel_arbiter.sv
// Round-robin arbiter sharing one AHB DMA master port between NUM_CH
// channels; sequences NONSEQ/SEQ beats and returns ack/done/err pulses.
module ahb_dma_channel_arbiter
   import ahb_dma_arb_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = $clog2(NUM_CH),
   parameter int BEAT_W = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH*BEAT_W-1:0] ch_beats,
   input  logic [NUM_CH*32-1:0]     ch_addr,
   input  logic [NUM_CH*32-1:0]     ch_wdata,
   input  logic [NUM_CH*3-1:0]      ch_size,
   input  logic [NUM_CH-1:0]        ch_we,
   output logic [NUM_CH-1:0]        ch_grant,
   output logic [NUM_CH-1:0]        ch_ack,
   output logic [NUM_CH-1:0]        ch_done,
   output logic [NUM_CH-1:0]        ch_err,
   output logic [31:0]              ch_rdata,
   output logic [31:0]              address,
   output logic [31:0]              write_data,
   output logic [2:0]               transfer_size,
   output logic                     write_enable,
   output logic                     no_trnasfer,
   output logic                     burst_seq_transfer,
   output logic [2:0]               burst,
   input  logic [31:0]              read_data,
   input  logic                     error,
   input  logic                     slave_wait
);

   arb_state_t         state_q;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [IDX_W-1:0]   owner_q;
   logic [NUM_CH-1:0]  grant_q;
   logic [BEAT_W-1:0]  beat_cnt_q;
   logic               first_beat_q;
   logic               burst_one_q;
   logic [NUM_CH-1:0]  done_q;
   logic [NUM_CH-1:0]  err_q;

   logic [NUM_CH-1:0]  pick_grant;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;
   logic [NUM_CH-1:0]  req_eff;
   logic [BEAT_W-1:0]  sel_beats;
   logic [BEAT_W-1:0]  load_beats;
   logic [IDX_W-1:0]   next_ptr;
   logic [1:0]         htrans;
   logic               xfer;
   logic               accept;

   // A channel being told done/err this cycle still holds its request; keep
   // it out of the next arbitration so it is not granted a phantom burst.
   assign req_eff = ch_req & ~(done_q | err_q);

   dma_rr_picker #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_picker (
      .req_i    (req_eff),
      .rr_ptr_i (rr_ptr_q),
      .grant_o  (pick_grant),
      .idx_o    (pick_idx),
      .valid_o  (pick_valid)
   );

   assign sel_beats  = ch_beats[pick_idx*BEAT_W +: BEAT_W];
   assign load_beats = (sel_beats == '0) ? BEAT_W'(1) : sel_beats;
   assign next_ptr   = (owner_q == IDX_W'(NUM_CH-1)) ? '0 : owner_q + 1'b1;

   assign xfer   = (state_q == XFER);
   assign accept = xfer && !error && ch_req[owner_q] && !slave_wait;
   assign htrans = htrans_of(xfer, first_beat_q);

   // Master-side mux: granted channel's controls during XFER, zeros otherwise.
   always_comb begin
      address       = '0;
      write_data    = '0;
      transfer_size = '0;
      write_enable  = 1'b0;
      burst         = '0;
      if (xfer) begin
         address       = ch_addr[owner_q*32 +: 32];
         write_data    = ch_wdata[owner_q*32 +: 32];
         transfer_size = ch_size[owner_q*3 +: 3];
         write_enable  = ch_we[owner_q];
         burst         = burst_one_q ? HBURST_SINGLE : HBURST_INCR;
      end
   end

   assign no_trnasfer        = (htrans == HTRANS_IDLE);
   assign burst_seq_transfer = (htrans == HTRANS_SEQ);
   assign ch_grant           = grant_q;
   assign ch_ack             = accept ? grant_q : '0;
   assign ch_done            = done_q;
   assign ch_err             = err_q;
   assign ch_rdata           = read_data;

   // Arbitration FSM: grant on request, count beats, release on last beat,
   // error or request withdrawal.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         grant_q      <= '0;
         beat_cnt_q   <= '0;
         first_beat_q <= 1'b0;
         burst_one_q  <= 1'b0;
         done_q       <= '0;
         err_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, regardless of statement order.
         done_q <= '0;
         err_q  <= '0;
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q      <= XFER;
                  grant_q      <= pick_grant;
                  owner_q      <= pick_idx;
                  beat_cnt_q   <= load_beats;
                  burst_one_q  <= (load_beats == BEAT_W'(1));
                  first_beat_q <= 1'b1;
               end
            end
            XFER: begin
               if (error || !ch_req[owner_q]) begin
                  err_q      <= error ? grant_q : '0;
                  state_q    <= IDLE;
                  grant_q    <= '0;
                  beat_cnt_q <= '0;
                  rr_ptr_q   <= next_ptr;
               end else if (!slave_wait) begin
                  first_beat_q <= 1'b0;
                  beat_cnt_q   <= beat_cnt_q - 1'b1;
                  if (beat_cnt_q == BEAT_W'(1)) begin
                     done_q   <= grant_q;
                     state_q  <= IDLE;
                     grant_q  <= '0;
                     rr_ptr_q <= next_ptr;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_dma_channel_arbiter.sv
// Scoreboard bench for ahb_dma_channel_arbiter: each test queues the beats
// and done/err events it expects, a monitor pops them as the DUT emits them.
module tb_ahb_dma_channel_arbiter;

   localparam int NUM_CH = 4;
   localparam int IDX_W  = 2;
   localparam int BEAT_W = 8;
   localparam int BUDGET = 200;

   typedef struct {
      int         ch;
      logic [31:0] addr;
      logic       seq;
      logic [2:0] burst;
      logic       we;
      logic [2:0] size;
   } beat_t;

   typedef struct {
      logic is_err;
      int   ch;
   } evt_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NUM_CH-1:0]        req = '0;
   logic [NUM_CH*BEAT_W-1:0] beats_bus;
   logic [NUM_CH*32-1:0]     addr_bus;
   logic [NUM_CH*32-1:0]     wdata_bus;
   logic [NUM_CH*3-1:0]      size_bus;
   logic [NUM_CH-1:0]        we_bus;
   logic [NUM_CH-1:0]        ch_grant, ch_ack, ch_done, ch_err;
   logic [31:0]              ch_rdata, address, write_data;
   logic [2:0]               transfer_size, burst;
   logic                     write_enable, no_trnasfer, burst_seq_transfer;
   logic [31:0]              read_data = '0;
   logic                     error = 1'b0;
   logic                     slave_wait = 1'b0;

   // Channel-side state
   logic [31:0]       a [NUM_CH];
   logic [BEAT_W-1:0] b [NUM_CH];
   logic [2:0]        s [NUM_CH];
   logic              w [NUM_CH];
   int                nbeats [NUM_CH];
   logic [NUM_CH-1:0] ack_seen = '0, done_seen = '0, err_seen = '0;

   int wait_ch = -1, wait_beat = 0, wait_left = 0;
   int err_ch = -1, err_beat = 0;

   beat_t beat_q[$];
   evt_t  evt_q[$];
   int    n_vec = 0;
   int    n_miss = 0;

   function automatic logic [31:0] wd(input logic [31:0] ad, input int c);
      return ad ^ (32'h5A00_0000 | 32'(c));
   endfunction

   always_comb begin
      addr_bus  = '0;
      wdata_bus = '0;
      beats_bus = '0;
      size_bus  = '0;
      we_bus    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         addr_bus[i*32 +: 32]      = a[i];
         wdata_bus[i*32 +: 32]     = wd(a[i], i);
         beats_bus[i*BEAT_W +: BEAT_W] = b[i];
         size_bus[i*3 +: 3]        = s[i];
         we_bus[i]                 = w[i];
      end
   end

   ahb_dma_channel_arbiter #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W),
      .BEAT_W (BEAT_W)
   ) dut (
      .clk_i              (clk),
      .rst_n_i            (rst_n),
      .ch_req             (req),
      .ch_beats           (beats_bus),
      .ch_addr            (addr_bus),
      .ch_wdata           (wdata_bus),
      .ch_size            (size_bus),
      .ch_we              (we_bus),
      .ch_grant           (ch_grant),
      .ch_ack             (ch_ack),
      .ch_done            (ch_done),
      .ch_err             (ch_err),
      .ch_rdata           (ch_rdata),
      .address            (address),
      .write_data         (write_data),
      .transfer_size      (transfer_size),
      .write_enable       (write_enable),
      .no_trnasfer        (no_trnasfer),
      .burst_seq_transfer (burst_seq_transfer),
      .burst              (burst),
      .read_data          (read_data),
      .error              (error),
      .slave_wait         (slave_wait)
   );

   task automatic start_req(input int c, input int nb, input logic [31:0] base,
                            input logic [2:0] sz, input logic we);
      b[c] = BEAT_W'(nb);
      a[c] = base;
      s[c] = sz;
      w[c] = we;
      nbeats[c] = 0;
      req[c] = 1'b1;
   endtask

   // Expected beats of a burst, in issue order, from the channel's start state.
   task automatic push_burst(input int c, input int n_ack, input int total);
      beat_t e;
      for (int k = 0; k < n_ack; k++) begin
         e.ch    = c;
         e.addr  = a[c] + 32'(k) * (32'd1 << s[c]);
         e.seq   = (k != 0);
         e.burst = (total <= 1) ? 3'b000 : 3'b001;
         e.we    = w[c];
         e.size  = s[c];
         beat_q.push_back(e);
      end
   endtask

   task automatic push_evt(input logic is_err, input int c);
      evt_t v;
      v.is_err = is_err;
      v.ch     = c;
      evt_q.push_back(v);
   endtask

   task automatic monitor();
      beat_t e;
      evt_t v;
      logic [NUM_CH-1:0] exp_v;
      if (slave_wait && ch_grant != '0) begin
         n_vec++;
         if (ch_ack !== '0) begin
            n_miss++;
            $display("FAIL wait_ack: ch_ack=%b required 0 while slave_wait", ch_ack);
         end
         if (beat_q.size() != 0) begin
            n_vec++;
            if (address !== beat_q[0].addr || burst_seq_transfer !== beat_q[0].seq) begin
               n_miss++;
               $display("FAIL wait_hold: addr=%h seq=%b required addr=%h seq=%b",
                        address, burst_seq_transfer, beat_q[0].addr, beat_q[0].seq);
            end
         end
      end
      if (error && ch_grant != '0) begin
         n_vec++;
         if (ch_ack !== '0) begin
            n_miss++;
            $display("FAIL err_ack: ch_ack=%b required 0 on error cycle", ch_ack);
         end
      end
      if (ch_ack !== '0) begin
         n_vec++;
         if (beat_q.size() == 0) begin
            n_miss++;
            $display("FAIL extra_ack: ch_ack=%b required no beat", ch_ack);
         end else begin
            e = beat_q.pop_front();
            exp_v = '0;
            exp_v[e.ch] = 1'b1;
            if (ch_ack !== exp_v) begin
               n_miss++;
               $display("FAIL beat_owner: ch_ack=%b required %b", ch_ack, exp_v);
            end
            n_vec++;
            if (address !== e.addr || write_data !== wd(e.addr, e.ch)) begin
               n_miss++;
               $display("FAIL beat_addr: addr=%h wdata=%h required addr=%h wdata=%h",
                        address, write_data, e.addr, wd(e.addr, e.ch));
            end
            n_vec++;
            if ({transfer_size, write_enable, burst, burst_seq_transfer, no_trnasfer}
                !== {e.size, e.we, e.burst, e.seq, 1'b0}) begin
               n_miss++;
               $display("FAIL beat_ctl: size=%0d we=%b burst=%b seq=%b no_tr=%b required size=%0d we=%b burst=%b seq=%b no_tr=0",
                        transfer_size, write_enable, burst, burst_seq_transfer, no_trnasfer,
                        e.size, e.we, e.burst, e.seq);
            end
            if (!e.we) begin
               n_vec++;
               if (ch_rdata !== read_data) begin
                  n_miss++;
                  $display("FAIL rdata: ch_rdata=%h required %h", ch_rdata, read_data);
               end
            end
         end
      end
      if ((ch_done | ch_err) !== '0) begin
         n_vec++;
         if (evt_q.size() == 0) begin
            n_miss++;
            $display("FAIL extra_evt: done=%b err=%b required none", ch_done, ch_err);
         end else begin
            v = evt_q.pop_front();
            exp_v = '0;
            exp_v[v.ch] = 1'b1;
            if (ch_done !== (v.is_err ? '0 : exp_v) || ch_err !== (v.is_err ? exp_v : '0)) begin
               n_miss++;
               $display("FAIL evt: done=%b err=%b required done=%b err=%b", ch_done, ch_err,
                        v.is_err ? '0 : exp_v, v.is_err ? exp_v : '0);
            end
            n_vec++;
            if (no_trnasfer !== 1'b1 || ch_grant !== '0) begin
               n_miss++;
               $display("FAIL idle_gap: no_tr=%b grant=%b required 1/0000", no_trnasfer, ch_grant);
            end
         end
      end
      ack_seen  = ch_ack;
      done_seen = ch_done;
      err_seen  = ch_err;
   endtask

   // One clock: channels react to last cycle's pulses, bus stimulus is set,
   // outputs are checked mid-cycle.
   task automatic tick();
      int own;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ack_seen[i]) begin
            a[i] = a[i] + (32'd1 << s[i]);
            nbeats[i]++;
         end
         if (done_seen[i] || err_seen[i]) req[i] = 1'b0;
      end
      ack_seen = '0;
      done_seen = '0;
      err_seen = '0;
      slave_wait = 1'b0;
      error = 1'b0;
      read_data = $urandom;
      own = -1;
      for (int i = 0; i < NUM_CH; i++) if (ch_grant[i]) own = i;
      if (own >= 0 && own == wait_ch && nbeats[own] == wait_beat && wait_left > 0) begin
         slave_wait = 1'b1;
         wait_left--;
      end
      if (own >= 0 && own == err_ch && nbeats[own] == err_beat) begin
         error = 1'b1;
         err_ch = -1;
      end
      @(negedge clk);
      monitor();
   endtask

   task automatic drain(input string tag);
      int cyc = 0;
      while ((beat_q.size() != 0 || evt_q.size() != 0 || req != '0) && cyc < BUDGET) begin
         tick();
         cyc++;
      end
      n_vec++;
      if (cyc >= BUDGET) begin
         n_miss++;
         $display("FAIL %s timeout: %0d beats %0d events pending, required 0",
                  tag, beat_q.size(), evt_q.size());
         beat_q.delete();
         evt_q.delete();
         req = '0;
      end
      tick();
      tick();
      n_vec++;
      if (no_trnasfer !== 1'b1 || ch_grant !== '0) begin
         n_miss++;
         $display("FAIL %s end_idle: no_tr=%b grant=%b required 1/0000", tag, no_trnasfer, ch_grant);
      end
   endtask

   task automatic test_reset();
      #12;
      n_vec++;
      if ({ch_grant, ch_ack, ch_done, ch_err} !== '0 || no_trnasfer !== 1'b1) begin
         n_miss++;
         $display("FAIL reset_ch: grant=%b ack=%b done=%b err=%b no_tr=%b required 0/0/0/0/1",
                  ch_grant, ch_ack, ch_done, ch_err, no_trnasfer);
      end
      n_vec++;
      if ({address, write_data, transfer_size, write_enable, burst, burst_seq_transfer} !== '0) begin
         n_miss++;
         $display("FAIL reset_bus: addr=%h wdata=%h size=%0d we=%b burst=%b seq=%b required all 0",
                  address, write_data, transfer_size, write_enable, burst, burst_seq_transfer);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_rr_pair();
      start_req(0, 4, 32'h0000_1000, 3'd2, 1'b1);
      start_req(2, 4, 32'h0000_2000, 3'd2, 1'b0);
      push_burst(0, 4, 4);
      push_evt(1'b0, 0);
      push_burst(2, 4, 4);
      push_evt(1'b0, 2);
      drain("rr_pair");
   endtask

   task automatic test_rr_ptr();
      // pointer sits at 3 after ch2, so ch3 beats ch1
      start_req(1, 1, 32'h0000_3000, 3'd2, 1'b1);
      start_req(3, 1, 32'h0000_4000, 3'd1, 1'b0);
      push_burst(3, 1, 1);
      push_evt(1'b0, 3);
      push_burst(1, 1, 1);
      push_evt(1'b0, 1);
      drain("rr_ptr");
   endtask

   task automatic test_single();
      start_req(0, 1, 32'h0000_5000, 3'd2, 1'b1);
      push_burst(0, 1, 1);
      push_evt(1'b0, 0);
      n_vec++;
      if (ch_grant !== '0) begin
         n_miss++;
         $display("FAIL single_pre_grant: grant=%b required 0000", ch_grant);
      end
      tick();
      n_vec++;
      if (ch_grant !== 4'b0001 || burst !== 3'b000) begin
         n_miss++;
         $display("FAIL single_grant: grant=%b burst=%b required 0001/000", ch_grant, burst);
      end
      drain("single");
   endtask

   task automatic test_wait();
      wait_ch = 0;
      wait_beat = 1;
      wait_left = 2;
      start_req(0, 3, 32'h0000_6000, 3'd2, 1'b1);
      push_burst(0, 3, 3);
      push_evt(1'b0, 0);
      drain("wait");
      wait_ch = -1;
   endtask

   task automatic test_error();
      err_ch = 1;
      err_beat = 1;
      start_req(1, 4, 32'h0000_7000, 3'd2, 1'b0);
      start_req(3, 2, 32'h0000_8000, 3'd0, 1'b1);
      push_burst(1, 1, 4);
      push_evt(1'b1, 1);
      push_burst(3, 2, 2);
      push_evt(1'b0, 3);
      drain("error");
      err_ch = -1;
   endtask

   task automatic test_zero_beats();
      start_req(2, 0, 32'h0000_9000, 3'd2, 1'b1);
      push_burst(2, 1, 0);
      push_evt(1'b0, 2);
      drain("zero_beats");
   endtask

   task automatic test_async_reset();
      start_req(1, 8, 32'h0000_A000, 3'd2, 1'b1);
      push_burst(1, 8, 8);
      tick();
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({ch_grant, ch_ack, ch_done, ch_err} !== '0 || no_trnasfer !== 1'b1 ||
          address !== '0 || burst !== '0 || burst_seq_transfer !== 1'b0) begin
         n_miss++;
         $display("FAIL async_reset: grant=%b ack=%b no_tr=%b addr=%h burst=%b required 0/0/1/0/0",
                  ch_grant, ch_ack, no_trnasfer, address, burst);
      end
      req = '0;
      beat_q.delete();
      evt_q.delete();
      ack_seen = '0;
      done_seen = '0;
      err_seen = '0;
      tick();
      tick();
      #2;
      rst_n = 1'b1;
      // pointer was 3 before reset; after reset ch0 must win over ch3
      start_req(0, 1, 32'h0000_B000, 3'd2, 1'b1);
      start_req(3, 1, 32'h0000_C000, 3'd2, 1'b0);
      push_burst(0, 1, 1);
      push_evt(1'b0, 0);
      push_burst(3, 1, 1);
      push_evt(1'b0, 3);
      drain("post_reset");
   endtask

   initial begin
      for (int i = 0; i < NUM_CH; i++) begin
         a[i] = '0;
         b[i] = '0;
         s[i] = '0;
         w[i] = 1'b0;
         nbeats[i] = 0;
      end
      test_reset();
      test_rr_pair();
      test_rr_ptr();
      test_single();
      test_wait();
      test_error();
      test_zero_beats();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
